// File: rtl/mbinit_pkg.sv
// Sideband codes and state encoding shared by the MBINIT REVERSALMB initiator and responder.
package mbinit_pkg;

  localparam logic [3:0] SB_REVMB_INIT_REQ     = 4'b0001;
  localparam logic [3:0] SB_REVMB_INIT_RESP    = 4'b0010;
  localparam logic [3:0] SB_REVMB_CLR_ERR_REQ  = 4'b0011;
  localparam logic [3:0] SB_REVMB_CLR_ERR_RESP = 4'b0100;
  localparam logic [3:0] SB_REVMB_RESULT_REQ   = 4'b0101;
  localparam logic [3:0] SB_REVMB_RESULT_RESP  = 4'b0110;
  localparam logic [3:0] SB_REVMB_DONE_REQ     = 4'b0111;
  localparam logic [3:0] SB_REVMB_DONE_RESP    = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_REQ  = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_SEND_RESP = 3'd3,
    ST_DONE      = 3'd4
  } revmb_state_e;

  function automatic logic is_revmb_req(input logic [3:0] code);
    case (code)
      SB_REVMB_INIT_REQ,
      SB_REVMB_CLR_ERR_REQ,
      SB_REVMB_RESULT_REQ,
      SB_REVMB_DONE_REQ: return 1'b1;
      default:           return 1'b0;
    endcase
  endfunction

  // Every REVERSALMB response code sits one above its request code.
  function automatic logic [3:0] revmb_resp_of(input logic [3:0] req);
    return req + 4'd1;
  endfunction

endpackage

// File: rtl/reversalmb_result_log.sv
// 16-bit lane-pass log: clear, OR-accumulate while enabled, hold otherwise (frozen).
module reversalmb_result_log (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_acc_en,
  input  logic [15:0] i_lane_pass,
  output logic [15:0] o_log
);

  logic [15:0] log_q;
  logic [15:0] log_d;

  always_comb begin
    log_d = log_q;
    if (i_clear) begin
      log_d = '0;
    end else if (i_acc_en) begin
      log_d = log_q | i_lane_pass;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      log_q <= '0;
    end else begin
      log_q <= log_d;
    end
  end

  assign o_log = log_q;

endmodule

// File: rtl/reversalmb_responder.sv
// Partner-side responder for the MBINIT.REVERSALMB sideband handshake.
// state        | meaning
// ST_IDLE      | disabled, everything cleared
// ST_WAIT_REQ  | waiting for a request (timeout runs once init_resp went out)
// ST_WAIT_BUSY | response latched, sideband TX still busy
// ST_SEND_RESP | response valid until the busy falling edge
// ST_DONE      | done_resp sent, hold until enable drops
module reversalmb_responder
  import mbinit_pkg::*;
#(
  parameter int                   TIMEOUT_W      = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'd8_000_000
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        i_REPAIRVAL_end,
  input  logic [3:0]  i_Rx_SbMessage,
  input  logic        i_msg_valid,
  input  logic        i_Busy_SideBand,
  input  logic        i_falling_edge_busy,
  input  logic [15:0] i_lane_pass,
  input  logic        i_lane_result_valid,
  output logic [3:0]  o_TX_SbMessage,
  output logic        o_ValidOutDatat_Module,
  output logic [15:0] o_REVERSAL_Result_logged,
  output logic        o_LaneID_Compare_En,
  output logic        o_MBINIT_REVERSALMB_Resp_end,
  output logic        o_train_error_req_responder,
  output logic        o_protocol_error
);

  localparam logic [TIMEOUT_W-1:0] TMR_RELOAD = TIMEOUT_CYCLES - TIMEOUT_W'(1);

  revmb_state_e         state_q, state_d;
  logic [3:0]           resp_q, resp_d;
  logic [3:0]           pend_q, pend_d;
  logic                 pend_v_q, pend_v_d;
  logic                 cmp_en_q, cmp_en_d;
  logic                 perr_q, perr_d;
  logic                 init_done_q, init_done_d;
  logic [TIMEOUT_W-1:0] tmr_q, tmr_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [3:0]           tx_msg_q, tx_msg_d;
  logic                 resp_end_q, resp_end_d;
  logic                 train_err_q, train_err_d;

  logic                 req_hit;
  logic                 send_exit;
  logic                 pend_take;
  logic                 log_clr;

  assign req_hit = i_msg_valid && is_revmb_req(i_Rx_SbMessage) &&
                   (state_q inside {ST_WAIT_REQ, ST_WAIT_BUSY, ST_SEND_RESP});
  assign send_exit = (state_q == ST_SEND_RESP) && i_falling_edge_busy && !i_Busy_SideBand;

  always_comb begin
    state_d     = state_q;
    resp_d      = resp_q;
    pend_d      = pend_q;
    pend_v_d    = pend_v_q;
    cmp_en_d    = cmp_en_q;
    perr_d      = perr_q;
    init_done_d = init_done_q;
    tmr_d       = TMR_RELOAD;
    train_err_d = 1'b0;
    pend_take   = 1'b0;
    log_clr     = 1'b0;

    if (!i_REPAIRVAL_end || state_q == ST_IDLE) begin
      resp_d      = '0;
      pend_d      = '0;
      pend_v_d    = 1'b0;
      cmp_en_d    = 1'b0;
      perr_d      = 1'b0;
      init_done_d = 1'b0;
      log_clr     = 1'b1;
      state_d     = i_REPAIRVAL_end ? ST_WAIT_REQ : ST_IDLE;
    end else begin
      if (req_hit) begin
        if (i_Rx_SbMessage == SB_REVMB_CLR_ERR_REQ) begin
          log_clr  = 1'b1;
          cmp_en_d = 1'b1;
        end
        if (i_Rx_SbMessage == SB_REVMB_RESULT_REQ) begin
          cmp_en_d = 1'b0;
        end
      end

      case (state_q)
        ST_WAIT_REQ: begin
          // A request caught on the SEND_RESP exit edge is served before new ones.
          if (pend_v_q) begin
            resp_d    = pend_q;
            pend_v_d  = 1'b0;
            pend_take = 1'b1;
            state_d   = i_Busy_SideBand ? ST_WAIT_BUSY : ST_SEND_RESP;
          end else if (req_hit) begin
            resp_d  = revmb_resp_of(i_Rx_SbMessage);
            state_d = i_Busy_SideBand ? ST_WAIT_BUSY : ST_SEND_RESP;
          end else if (init_done_q) begin
            if (tmr_q == '0) begin
              train_err_d = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              tmr_d = tmr_q - TIMEOUT_W'(1);
            end
          end
        end
        ST_WAIT_BUSY: begin
          if (!i_Busy_SideBand) begin
            state_d = ST_SEND_RESP;
          end
        end
        ST_SEND_RESP: begin
          if (send_exit) begin
            if (resp_q == SB_REVMB_INIT_RESP) begin
              init_done_d = 1'b1;
            end
            if (resp_q == SB_REVMB_DONE_RESP) begin
              state_d = ST_DONE;
            end else if (pend_v_q) begin
              resp_d    = pend_q;
              pend_v_d  = 1'b0;
              pend_take = 1'b1;
              state_d   = ST_WAIT_BUSY;
            end else begin
              state_d = ST_WAIT_REQ;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (req_hit && (state_q != ST_WAIT_REQ || pend_v_q)) begin
        if (pend_v_q && !pend_take) begin
          perr_d = 1'b1;
        end
        pend_d   = revmb_resp_of(i_Rx_SbMessage);
        pend_v_d = 1'b1;
      end
    end

    tx_valid_d = (state_d == ST_SEND_RESP);
    tx_msg_d   = tx_valid_d ? resp_d : 4'b0000;
    resp_end_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      resp_q      <= '0;
      pend_q      <= '0;
      pend_v_q    <= 1'b0;
      cmp_en_q    <= 1'b0;
      perr_q      <= 1'b0;
      init_done_q <= 1'b0;
      tmr_q       <= TMR_RELOAD;
      tx_valid_q  <= 1'b0;
      tx_msg_q    <= '0;
      resp_end_q  <= 1'b0;
      train_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      resp_q      <= resp_d;
      pend_q      <= pend_d;
      pend_v_q    <= pend_v_d;
      cmp_en_q    <= cmp_en_d;
      perr_q      <= perr_d;
      init_done_q <= init_done_d;
      tmr_q       <= tmr_d;
      tx_valid_q  <= tx_valid_d;
      tx_msg_q    <= tx_msg_d;
      resp_end_q  <= resp_end_d;
      train_err_q <= train_err_d;
    end
  end

  reversalmb_result_log u_result_log (
    .clk         (CLK),
    .rst         (rst),
    .i_clear     (log_clr),
    .i_acc_en    (cmp_en_q && i_lane_result_valid),
    .i_lane_pass (i_lane_pass),
    .o_log       (o_REVERSAL_Result_logged)
  );

  assign o_TX_SbMessage               = tx_msg_q;
  assign o_ValidOutDatat_Module       = tx_valid_q;
  assign o_LaneID_Compare_En          = cmp_en_q;
  assign o_MBINIT_REVERSALMB_Resp_end = resp_end_q;
  assign o_train_error_req_responder  = train_err_q;
  assign o_protocol_error             = perr_q;

endmodule

// File: tb/tb_reversalmb_responder.sv
// Bench for reversalmb_responder: directed scenarios plus randomized full handshakes against a log/enable model.
module tb_reversalmb_responder;

  localparam logic [3:0] INIT = 4'b0001;
  localparam logic [3:0] CLR  = 4'b0011;
  localparam logic [3:0] RES  = 4'b0101;
  localparam logic [3:0] DN   = 4'b0111;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  rx_msg;
  logic        msg_v;
  logic        busy;
  logic        fe;
  logic [15:0] lane_pass;
  logic        lane_v;
  logic [3:0]  tx_msg;
  logic        tx_v;
  logic [15:0] log_o;
  logic        cmp_en;
  logic        resp_end;
  logic        terr;
  logic        perr;

  always #5 clk = ~clk;

  reversalmb_responder #(
    .TIMEOUT_W      (24),
    .TIMEOUT_CYCLES (24'd100)
  ) dut (
    .CLK                          (clk),
    .rst                          (rst),
    .i_REPAIRVAL_end              (en),
    .i_Rx_SbMessage               (rx_msg),
    .i_msg_valid                  (msg_v),
    .i_Busy_SideBand              (busy),
    .i_falling_edge_busy          (fe),
    .i_lane_pass                  (lane_pass),
    .i_lane_result_valid          (lane_v),
    .o_TX_SbMessage               (tx_msg),
    .o_ValidOutDatat_Module       (tx_v),
    .o_REVERSAL_Result_logged     (log_o),
    .o_LaneID_Compare_En          (cmp_en),
    .o_MBINIT_REVERSALMB_Resp_end (resp_end),
    .o_train_error_req_responder  (terr),
    .o_protocol_error             (perr)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          terr_cnt = 0;
  logic [15:0] m_log = '0;
  bit          m_cmp = 1'b0;

  always @(negedge clk) if (terr === 1'b1) terr_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] resp_of(input logic [3:0] r);
    case (r)
      4'b0001: return 4'b0010;
      4'b0011: return 4'b0100;
      4'b0101: return 4'b0110;
      4'b0111: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic m_clear();
    m_log = '0;
    m_cmp = 1'b0;
  endtask

  // One clock with optional request and lane strobe; the model applies the strobe, then the request.
  task automatic step(input bit rq, input logic [3:0] code, input bit sv, input logic [15:0] pass);
    msg_v = rq; rx_msg = code; lane_v = sv; lane_pass = pass;
    cyc();
    msg_v = 1'b0; rx_msg = '0; lane_v = 1'b0; lane_pass = '0;
    if (sv && m_cmp) m_log = m_log | pass;
    if (rq && code == CLR) begin m_log = '0; m_cmp = 1'b1; end
    if (rq && code == RES) m_cmp = 1'b0;
    chk("log", log_o, m_log);
    chk("cmp_en", cmp_en, m_cmp);
  endtask

  task automatic release_busy(input bit rq, input logic [3:0] code);
    busy = 1'b0; fe = 1'b1;
    step(rq, code, 1'b0, 16'h0);
    fe = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, tx_v, 1'b0);
    chk({tag, "_code"}, tx_msg, 4'h0);
    chk({tag, "_cmp"}, cmp_en, 1'b0);
    chk({tag, "_end"}, resp_end, 1'b0);
    chk({tag, "_terr"}, terr, 1'b0);
    chk({tag, "_perr"}, perr, 1'b0);
    chk({tag, "_log"}, log_o, 16'h0);
  endtask

  task automatic handshake(input logic [3:0] code, input int busy_pre, input int busy_len,
                           input bit sv, input logic [15:0] pass);
    busy = (busy_pre > 0);
    step(1'b1, code, sv, pass);
    for (int i = 0; i < busy_pre; i++) begin
      chk("no_valid_while_busy", tx_v, 1'b0);
      cyc();
    end
    if (busy_pre > 0) begin
      busy = 1'b0; fe = 1'b1;
      cyc();
      fe = 1'b0;
    end
    chk("resp_valid", tx_v, 1'b1);
    chk("resp_code", tx_msg, resp_of(code));
    chk("resp_log", log_o, m_log);
    busy = 1'b1;
    for (int i = 0; i < busy_len; i++) begin
      cyc();
      chk("valid_hold", tx_v, 1'b1);
    end
    release_busy(1'b0, 4'h0);
    chk("valid_drop", tx_v, 1'b0);
  endtask

  task automatic disable_en();
    en = 1'b0;
    cyc();
    m_clear();
    chk_zero("disable");
    en = 1'b1;
    cyc();
  endtask

  task automatic idle_gap(input int g);
    logic [3:0] bad [12] = '{4'h0, 4'h2, 4'h4, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    for (int i = 0; i < g; i++) begin
      if (i == g - 1) begin
        step(1'b1, bad[$urandom_range(0, 11)], 1'b0, 16'h0);
        chk("ignored_code", tx_v, 1'b0);
      end else begin
        step(1'b0, 4'h0, 1'($urandom_range(0, 1)), 16'($urandom));
      end
    end
  endtask

  initial begin
    int n;
    int base;
    rst = 1'b1; en = 1'b0; rx_msg = '0; msg_v = 1'b0; busy = 1'b0; fe = 1'b0;
    lane_pass = '0; lane_v = 1'b0;
    cyc(); cyc();
    chk_zero("reset");
    rst = 1'b0;
    cyc();
    en = 1'b1;
    cyc();

    // Full sequence
    handshake(INIT, 0, 2, 1'b0, 16'h0);
    handshake(CLR, 0, 1, 1'b0, 16'h0);
    step(1'b0, 4'h0, 1'b1, 16'h00FF);
    step(1'b0, 4'h0, 1'b1, 16'hFF00);
    handshake(RES, 0, 2, 1'b0, 16'h0);
    chk("full_log", log_o, 16'hFFFF);
    handshake(DN, 0, 1, 1'b0, 16'h0);
    chk("full_resp_end", resp_end, 1'b1);
    disable_en();

    // Busy held on init_req
    handshake(INIT, 5, 1, 1'b0, 16'h0);

    // Pending slot and overrun during clear_error_resp
    step(1'b1, CLR, 1'b0, 16'h0);
    chk("pend_clr_valid", tx_v, 1'b1);
    chk("pend_clr_code", tx_msg, 4'b0100);
    busy = 1'b1;
    cyc();
    step(1'b1, RES, 1'b0, 16'h0);
    chk("pend_no_perr", perr, 1'b0);
    chk("pend_still_valid", tx_v, 1'b1);
    step(1'b1, RES, 1'b0, 16'h0);
    chk("pend_overrun_perr", perr, 1'b1);
    release_busy(1'b0, 4'h0);
    chk("pend_gap", tx_v, 1'b0);
    cyc();
    chk("pend_res_valid", tx_v, 1'b1);
    chk("pend_res_code", tx_msg, 4'b0110);
    busy = 1'b1;
    cyc();
    release_busy(1'b1, DN);
    chk("exit_req_gap", tx_v, 1'b0);
    cyc();
    chk("exit_req_valid", tx_v, 1'b1);
    chk("exit_req_code", tx_msg, 4'b1000);
    busy = 1'b1;
    cyc();
    release_busy(1'b0, 4'h0);
    chk("exit_req_end", resp_end, 1'b1);
    chk("perr_sticky", perr, 1'b1);
    disable_en();

    // Lane strobe coinciding with result_req
    handshake(INIT, 0, 0, 1'b0, 16'h0);
    handshake(CLR, 0, 0, 1'b0, 16'h0);
    handshake(RES, 0, 1, 1'b1, 16'h0001);
    chk("coincident_log", log_o, 16'h0001);
    step(1'b0, 4'h0, 1'b1, 16'h8000);
    chk("frozen_log", log_o, 16'h0001);
    handshake(DN, 0, 0, 1'b0, 16'h0);
    disable_en();

    // Enable dropped mid SEND_RESP
    handshake(INIT, 0, 0, 1'b0, 16'h0);
    handshake(CLR, 0, 0, 1'b0, 16'h0);
    step(1'b0, 4'h0, 1'b1, 16'hFFFF);
    step(1'b1, RES, 1'b0, 16'h0);
    chk("drop_valid_before", tx_v, 1'b1);
    busy = 1'b1;
    cyc();
    en = 1'b0;
    cyc();
    m_clear();
    chk_zero("en_drop");
    busy = 1'b0;
    en = 1'b1;
    cyc();

    // Async reset mid log
    handshake(INIT, 0, 0, 1'b0, 16'h0);
    handshake(CLR, 0, 0, 1'b0, 16'h0);
    step(1'b0, 4'h0, 1'b1, 16'h1234);
    #2 rst = 1'b1;
    #1;
    m_clear();
    chk_zero("rst_async");
    @(negedge clk);
    rst = 1'b0;
    cyc();
    chk("rst_log_after", log_o, 16'h0);

    // Timeout after init_resp
    base = terr_cnt;
    handshake(INIT, 0, 1, 1'b0, 16'h0);
    n = 0;
    while (terr !== 1'b1 && n < 300) begin
      cyc();
      n++;
    end
    chk("timeout_cycles", n, 100);
    cyc();
    chk("timeout_pulse_width", terr, 1'b0);
    chk("timeout_valid", tx_v, 1'b0);
    repeat (150) cyc();
    chk("timeout_single_pulse", terr_cnt - base, 1);
    disable_en();

    // Randomized full sequences
    base = terr_cnt;
    for (int r = 0; r < 15; r++) begin
      idle_gap($urandom_range(0, 10));
      handshake(INIT, $urandom_range(0, 3), $urandom_range(0, 4), 1'b0, 16'h0);
      idle_gap(r == 0 ? 98 : $urandom_range(0, 20));
      handshake(CLR, $urandom_range(0, 3), $urandom_range(0, 4), 1'b0, 16'h0);
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b1, 16'($urandom));
      handshake(RES, $urandom_range(0, 3), $urandom_range(0, 4),
                1'($urandom_range(0, 1)), 16'($urandom));
      step(1'b0, 4'h0, 1'b1, 16'($urandom));
      handshake(DN, $urandom_range(0, 3), $urandom_range(0, 4), 1'b0, 16'h0);
      chk("rand_resp_end", resp_end, 1'b1);
      disable_en();
    end
    chk("no_spurious_timeout", terr_cnt - base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
